inv_sub_bytes_seq: RTL and testbench
====================================

# inv_sub_bytes_seq

Sequential AES InvSubBytes stage. It sits directly downstream of the InvShiftRows stage in the decryption round datapath. The block accepts one 128-bit state per handshake and replaces every byte with its inverse S-box value, processing LANES bytes per clock. It returns the result through a valid/ready output handshake, so that a small number of inverse S-box instances is time-shared across the 16 state bytes.

## Interface
- LANES, default 4: inverse S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is a compile-time error.
- N (localparam) = 16/LANES: number of RUN cycles per block.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a state on in_state.
- in_ready  output  1  block can accept a state; high only in IDLE.
- in_state  input  128  input state, byte 0 at [127:120] through byte 15 at [7:0]. Column-major AES order: column c occupies [127-32c -: 32].
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  the working register; same byte order as in_state.
- busy  output  1  high in RUN or DONE.

## Operation
- States are IDLE, RUN and DONE, plus an internal counter cnt of width max(1, log2(N)) and a 128-bit working register W.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, W <= in_state, cnt <= 0, go to RUN.
  - Otherwise stay in IDLE; W holds.
- RUN:
  - Each cycle, bytes cnt*LANES through cnt*LANES+LANES-1 of W are replaced by InvSBox(byte). Byte k is W[127-8k -: 8]. All other bytes hold.
  - cnt increments each cycle.
  - When cnt == N-1, that cycle's update completes the block, cnt wraps to 0, and the FSM goes to DONE.
  - For LANES=16 (N=1), RUN lasts exactly one cycle.
- DONE:
  - out_valid = 1; W and out_state are held stable until the handshake.
  - On out_ready, go to IDLE.
  - in_valid is ignored in DONE (in_ready = 0).
- InvSBox is the FIPS-197 inverse S-box, a full 256-entry mapping that is combinational and shared by all lanes. Examples: 0x63 maps to 0x00, 0x00 to 0x52, 0x7c to 0x01, 0x16 to 0xff, 0xed to 0x53.
- out_state always reflects W. During RUN it holds a partially substituted state and must only be sampled when out_valid = 1.
- in_state is sampled only on the accept edge. Changes to in_state afterwards have no effect.
- Reset (asserting rst_n = 0 at any time, including mid-RUN or in DONE):
  - FSM goes to IDLE immediately; W = 0; cnt = 0.
  - out_valid = 0, busy = 0, out_state = 0.
  - in_ready = 1 once rst_n is high; it is already 1 combinationally during reset, since it is decoded from IDLE.
  - Any block in flight is discarded; nothing is emitted after reset releases.
- Outputs in_ready, out_valid and busy are decoded directly from the state register, with no combinational path from inputs.

## Timing
- Accept occurs on edge E0, where in_valid && in_ready.
- RUN updates occur on edges E1..EN; out_valid rises after EN, i.e. N cycles after accept (LANES=4 gives 4 cycles).
- If out_ready is high while out_valid is high, the output handshake completes on edge EN+1, and the next accept can occur at the earliest on EN+2. Throughput is therefore one block per N+2 cycles.
- If out_ready is held low, DONE persists indefinitely with out_state stable, and in_ready stays low (backpressure).
- Simultaneous in_valid and out_ready in DONE: only the output handshake occurs; the input is accepted in IDLE on the following edge, provided in_valid is still high.
- out_ready in IDLE or RUN has no effect.

## Test plan
- Reset values: assert rst_n=0 -> in_ready=1, out_valid=0, busy=0, out_state=0.
- Known vector with LANES=4 and out_ready=1: in_state=128'h637c777bf26b6fc53001672bfed7ab76 -> out_state=128'h000102030405060708090a0b0c0d0e0f. out_valid rises 4 cycles after accept and drops after 1 cycle.
- Uniform vectors: in_state all bytes 0x63 -> out_state all 0x00. Then in_state all 0x00 -> out_state all 0x52. Issue them back-to-back with in_valid held high; the second accept occurs exactly 6 cycles after the first.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, and toggle in_state and in_valid meanwhile -> out_state unchanged, in_ready=0. When out_ready=1, exactly one handshake occurs.
- Mid-operation reset: pulse rst_n low during the 2nd RUN cycle -> out_valid never asserts for that block, out_state=0, and the next block yields a correct result.
- Parameter sweep: LANES=1 and LANES=16 on the 0x637c… vector -> identical result, with latencies of 16 and 1 cycles respectively. The bench also runs an exhaustive 256-byte check against a reference inverse S-box model.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// inv_sub_bytes_seq : AES InvSubBytes over a 128-bit state, LANES bytes/cycle
// Revision: 1.0
// ============================================================================
module inv_sub_bytes_seq #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int c_n  = 16 / LANES;
   localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   // FIPS-197 inverse S-box, entry 0 in the most significant byte
   localparam logic [0:255][7:0] c_isbox = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return c_isbox[b];
   endfunction

   logic [1:0]      r_state;
   logic [1:0]      w_next;
   logic [c_cw-1:0] r_cnt;
   logic [127:0]    r_w;
   logic [127:0]    w_upd;
   logic [7:0]      w_lane_in  [LANES];
   logic [7:0]      w_lane_out [LANES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:  if (in_valid)          w_next = c_run;
         c_run:   if (r_cnt == c_last)   w_next = c_done;
         c_done:  if (out_ready)         w_next = c_idle;
         default:                        w_next = c_idle;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == c_idle);
      out_valid = (r_state == c_done);
      busy      = (r_state == c_run) || (r_state == c_done);
   end

   // Lane l serves bytes l, l+LANES, ...; r_cnt picks which group is live
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_lane_in[l] = 8'h00;
         for (int g = 0; g < c_n; g++) begin
            if (r_cnt == c_cw'(g)) begin
               w_lane_in[l] = r_w[127 - 8*(g*LANES + l) -: 8];
            end
         end
         w_lane_out[l] = inv_sbox(w_lane_in[l]);
      end
   end

   generate
      for (genvar k = 0; k < 16; k++) begin : g_byte
         assign w_upd[127 - 8*k -: 8] = (r_cnt == c_cw'(k / LANES)) ? w_lane_out[k % LANES]
                                                                    : r_w[127 - 8*k -: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w   <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (in_valid) begin
                  r_w   <= in_state;
                  r_cnt <= '0;
               end
            end
            c_run: begin
               r_w   <= w_upd;
               r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cw'(1);
            end
            default: ;
         endcase
      end
   end

   assign out_state = r_w;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// tb_inv_sub_bytes_seq : self-checking bench for inv_sub_bytes_seq
// Revision: 1.0
// ============================================================================
module tb_inv_sub_bytes_seq;

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   localparam logic [127:0] c_kin  = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] c_kout = 128'h000102030405060708090a0b0c0d0e0f;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, out_ready;
   logic [127:0] in_state;
   logic         in_ready, out_valid, busy;
   logic [127:0] out_state;

   logic         sv_valid;
   logic [127:0] sv_state;
   logic         s1_ir, s1_ov, s1_busy, s16_ir, s16_ov, s16_busy;
   logic [127:0] s1_os, s16_os;

   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           last_acc = 0;
   int           n_hs = 0;
   logic [127:0] exp_q [$];
   int           acc_log [$];
   logic [7:0]   isbox [256];
   vec_t         vecs [23];

   always #5 clk = ~clk;

   inv_sub_bytes_seq #(.LANES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state), .busy(busy)
   );

   inv_sub_bytes_seq #(.LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(sv_valid), .in_ready(s1_ir),
      .in_state(sv_state), .out_valid(s1_ov), .out_ready(1'b1),
      .out_state(s1_os), .busy(s1_busy)
   );

   inv_sub_bytes_seq #(.LANES(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(sv_valid), .in_ready(s16_ir),
      .in_state(sv_state), .out_valid(s16_ov), .out_ready(1'b1),
      .out_state(s16_os), .busy(s16_busy)
   );

   // Reference inverse S-box built from GF(2^8) inversion + affine map
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_model();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         isbox[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_state(input logic [127:0] d);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = isbox[d[127 - 8*k -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: logs accepts, checks output latency, pops the scoreboard
   initial begin
      logic prev_ov;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && in_valid && in_ready) begin
            last_acc = cyc + 1;
            acc_log.push_back(cyc + 1);
         end
         if (rst_n && out_valid && !prev_ov) chk("latency", 128'(cyc - last_acc), 128'd4);
         if (rst_n && out_valid && out_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected output: got %h, expected no output", out_state);
            end else begin
               chk("out_state", out_state, exp_q.pop_front());
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic send(input logic [127:0] d, input logic [127:0] e);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("send in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_state = d;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_state = rnd128();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain timeout: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("out_valid rise", out_valid, 1);
   endtask

   initial begin
      logic [127:0] d;
      int           hs0, a1, r1, r16;
      logic [127:0] o1, o16;

      build_model();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
      sv_valid = 1'b0; sv_state = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready",  in_ready,  1);
      chk("rst out_valid", out_valid, 0);
      chk("rst busy",      busy,      0);
      chk("rst out_state", out_state, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle in_ready", in_ready, 1);

      vecs[0] = '{c_kin, c_kout};
      vecs[1] = '{{16{8'h63}}, 128'h0};
      vecs[2] = '{128'h0, {16{8'h52}}};
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 16; k++) d[127 - 8*k -: 8] = 8'(16*i + k);
         vecs[3 + i] = '{d, ref_state(d)};
      end
      for (int i = 0; i < 4; i++) begin
         d = rnd128();
         vecs[19 + i] = '{d, ref_state(d)};
      end
      for (int i = 0; i < 23; i++) begin
         send(vecs[i].din, vecs[i].dout);
         drain();
      end

      // out_valid is a single-cycle pulse when downstream is ready
      send(c_kin, c_kout);
      wait_valid();
      @(posedge clk); #1;
      chk("out_valid drop", out_valid, 0);
      drain();

      // back-to-back with in_valid held high
      acc_log.delete();
      in_valid = 1'b1;
      in_state = {16{8'h63}};
      exp_q.push_back(128'h0);
      @(posedge clk); #1;
      in_state = 128'h0;
      exp_q.push_back({16{8'h52}});
      repeat (7) @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();
      chk("b2b accepts", 128'(acc_log.size()), 128'd2);
      if (acc_log.size() >= 2) chk("b2b spacing", 128'(acc_log[1] - acc_log[0]), 128'd6);

      // backpressure
      out_ready = 1'b0;
      d = rnd128();
      send(d, ref_state(d));
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_state = rnd128();
         @(posedge clk); #1;
         chk("bp in_ready",  in_ready,  0);
         chk("bp out_state", out_state, ref_state(d));
      end
      in_valid = 1'b0;
      hs0 = n_hs;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("bp handshakes", 128'(n_hs - hs0), 128'd1);
      chk("bp back idle", in_ready, 1);

      // reset during the second RUN cycle
      d = rnd128();
      send(d, ref_state(d));
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      #2;
      chk("mid-rst out_state", out_state, 0);
      chk("mid-rst busy",      busy,      0);
      chk("mid-rst out_valid", out_valid, 0);
      chk("mid-rst in_ready",  in_ready,  1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      hs0 = n_hs;
      repeat (10) @(posedge clk);
      #1;
      chk("post-rst no output", 128'(n_hs - hs0), 128'd0);
      chk("post-rst out_valid", out_valid, 0);
      d = rnd128();
      send(d, ref_state(d));
      drain();

      // LANES=1 and LANES=16 on the known vector
      sv_state = c_kin;
      sv_valid = 1'b1;
      @(posedge clk); #1;
      a1 = cyc;
      sv_valid = 1'b0;
      sv_state = rnd128();
      r1 = -1; r16 = -1; o1 = 'x; o16 = 'x;
      for (int t = 0; t < 40 && (r1 < 0 || r16 < 0); t++) begin
         if (s1_ov && r1 < 0) begin r1 = cyc; o1 = s1_os; end
         if (s16_ov && r16 < 0) begin r16 = cyc; o16 = s16_os; end
         @(posedge clk); #1;
      end
      chk("lanes1 latency",  128'(r1 - a1),  128'd16);
      chk("lanes1 state",    o1,  c_kout);
      chk("lanes16 latency", 128'(r16 - a1), 128'd1);
      chk("lanes16 state",   o16, c_kout);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
